// File: rtl/aes_128_dec.sv
// aes_128_dec: iterative AES-128 inverse cipher, derives rk10 then runs one inverse round per cycle.
// Optional define AES_DEC_KEY_CACHE_EN keeps the last key and its rk10 so a repeated key skips expansion.

module S_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y = TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module inv_s_box (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign y = TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module aes_128_dec (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] pt
);
    // state | meaning
    // IDLE  | waiting for a ciphertext/key pair
    // KEXP  | forward key expansion up to rk10
    // ROUND | inverse rounds 9..0, key schedule unwound in step
    // DONE  | plaintext presented until consumed
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    state_t       state;
    logic [127:0] s;
    logic [127:0] k;
    logic [3:0]   cnt;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] f);
        logic [7:0] b2, b4, b8;
        b2 = xt(b);
        b4 = xt(b2);
        b8 = xt(b4);
        return (f[3] ? b8 : 8'h00) ^ (f[2] ? b4 : 8'h00) ^
               (f[1] ? b2 : 8'h00) ^ (f[0] ? b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
        return {inv_mix_col(x[127:96]), inv_mix_col(x[95:64]),
                inv_mix_col(x[63:32]), inv_mix_col(x[31:0])};
    endfunction

    // Forward and inverse schedules never run together, so they share one SubWord.
    logic [31:0]  sub_src;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [31:0]  rc_word;
    logic [31:0]  w0_fwd, w1_fwd, w2_fwd, w3_fwd;
    logic [127:0] key_fwd;
    logic [127:0] key_inv;

    assign sub_src  = (state == KEXP) ? k[31:0] : (k[31:0] ^ k[63:32]);
    assign rot_word = {sub_src[23:0], sub_src[31:24]};
    assign rc_word  = {rcon(cnt), 24'h000000};

    for (genvar j = 0; j < 4; j++) begin : g_sub
        S_box u_sbox (.a(rot_word[8*j +: 8]), .y(sub_word[8*j +: 8]));
    end

    assign w0_fwd  = k[127:96] ^ sub_word ^ rc_word;
    assign w1_fwd  = k[95:64] ^ w0_fwd;
    assign w2_fwd  = k[63:32] ^ w1_fwd;
    assign w3_fwd  = k[31:0] ^ w2_fwd;
    assign key_fwd = {w0_fwd, w1_fwd, w2_fwd, w3_fwd};

    assign key_inv = {k[127:96] ^ sub_word ^ rc_word,
                      k[95:64] ^ k[127:96],
                      k[63:32] ^ k[95:64],
                      k[31:0] ^ k[63:32]};

    // InvShiftRows is pure wiring folded into which state byte feeds each inverse S-box.
    logic [127:0] isb;
    logic [127:0] t;
    logic [127:0] round_out;

    for (genvar b = 0; b < 16; b++) begin : g_isb
        localparam int ROW = b % 4;
        localparam int SRC = ROW + 4 * (((b / 4) - ROW + 4) % 4);
        inv_s_box u_isbox (.a(s[127 - 8*SRC -: 8]), .y(isb[127 - 8*b -: 8]));
    end

    assign t         = isb ^ key_inv;
    assign round_out = (cnt != 4'd0) ? inv_mix_columns(t) : t;

    logic         cache_hit;
    logic [127:0] hit_rk10;

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] key_hold;
    logic [127:0] cached_key;
    logic [127:0] cached_rk10;
    logic         cache_vld;

    assign cache_hit = cache_vld && (key == cached_key);
    assign hit_rk10  = cached_rk10;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_hold    <= '0;
            cached_key  <= '0;
            cached_rk10 <= '0;
            cache_vld   <= 1'b0;
        end else begin
            if (state == IDLE && in_valid && in_ready) begin
                key_hold <= key;
            end
            if (state == KEXP && cnt == 4'd9) begin
                cached_key  <= key_hold;
                cached_rk10 <= key_fwd;
                cache_vld   <= 1'b1;
            end
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_rk10  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            s         <= '0;
            k         <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        if (cache_hit) begin
                            k     <= hit_rk10;
                            s     <= ct ^ hit_rk10;
                            cnt   <= 4'd9;
                            state <= ROUND;
                        end else begin
                            k     <= key;
                            s     <= ct;
                            cnt   <= 4'd0;
                            state <= KEXP;
                        end
                    end
                end
                KEXP: begin
                    k <= key_fwd;
                    if (cnt == 4'd9) begin
                        s     <= s ^ key_fwd;
                        state <= ROUND;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                ROUND: begin
                    k <= key_inv;
                    s <= round_out;
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pt = s;
endmodule

// File: tb/tb_aes_128_dec.sv
// Directed bench for aes_128_dec: scoreboard of expected plaintext and latency per accepted block.
module tb_aes_128_dec;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] ct = '0;
    logic [127:0] key = '0;
    logic [127:0] pt;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;
    exp_t sb[$];

    logic         mdl_vld = 1'b0;
    logic [127:0] mdl_key = '0;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    localparam logic [127:0] CT1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT2  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT3  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] CT4  = 128'h0545aad56da2a97c3663d1432a3d1c84;
    localparam logic [127:0] CT5  = 128'h58e2fccefa7e3061367f1d57a4e7455a;

    aes_128_dec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pt        (pt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [127:0] k_in, input logic [127:0] p);
        exp_t e;
        e.pt  = p;
        e.acc = cyc;
        if (CACHE && mdl_vld && k_in == mdl_key) begin
            e.lat = 10;
        end else begin
            e.lat   = 20;
            mdl_vld = 1'b1;
            mdl_key = k_in;
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, 128'(in_ready), 128'd1);
    endtask

    task automatic send(input string tag, input logic [127:0] c, input logic [127:0] k_in,
                        input logic [127:0] p);
        wait_ready(tag);
        ct       = c;
        key      = k_in;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        push(k_in, p);
    endtask

    task automatic wait_output(input string tag);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid_timeout"}, 128'(out_valid), 128'd1);
        check({tag, "_sb_nonempty"}, 128'(sb.size() > 0), 128'd1);
        if (out_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_pt"}, pt, e.pt);
            check({tag, "_lat"}, 128'(cyc - e.acc), 128'(e.lat));
        end
    endtask

    initial begin
        int ov_cyc;
        int acc2;
        logic [127:0] held;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_pt", pt, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // abort a block mid-ROUND
        send("abort", CT1, KEY1, PT1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 128'(out_valid), 128'd0);
        check("abort_in_ready", 128'(in_ready), 128'd1);
        check("abort_pt", pt, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        mdl_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_in_ready", 128'(in_ready), 128'd1);
            check("post_abort_out_valid", 128'(out_valid), 128'd0);
        end

        out_ready = 1'b1;
        send("v1", CT1, KEY1, PT1);
        wait_output("v1");
        @(negedge clk);
        check("v1_pulse_low", 128'(out_valid), 128'd0);

        send("v2", CT2, KEY2, PT2);
        wait_output("v2");
        @(negedge clk);

        // back-pressure: hold DONE for 7 cycles
        out_ready = 1'b0;
        send("v3", CT3, 128'd0, 128'd0);
        wait_output("v3");
        held = pt;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("hold_pt", pt, held);
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("hold_release", 128'(out_valid), 128'd0);

        // back-to-back with in_valid held high
        wait_ready("b2b0");
        ct       = CT4;
        key      = 128'd1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        push(128'd1, 128'd0);
        ct  = CT5;
        key = 128'd0;
        wait_output("b2b0");
        ov_cyc = cyc;
        @(negedge clk);
        wait_ready("b2b1");
        @(posedge clk);
        @(negedge clk);
        acc2 = cyc;
        push(128'd0, 128'd1);
        in_valid = 1'b0;
        check("b2b_gap", 128'(acc2 - ov_cyc), 128'd2);
        wait_output("b2b1");
        @(negedge clk);

        // repeated key, then a different key
        send("rep0", CT2, KEY2, PT2);
        wait_output("rep0");
        @(negedge clk);
        send("rep1", CT2, KEY2, PT2);
        wait_output("rep1");
        @(negedge clk);
        send("newkey", CT1, KEY1, PT1);
        wait_output("newkey");
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
